// File: rtl/bit_scatter32_pkg.sv
// Shared types and constants for the bit_scatter32 block.
package bit_scatter32_pkg;

    localparam int unsigned SET_W = 32;
    localparam int unsigned IDX_W = 5;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/bit_scatter32_if.sv
// Write/output handshake bundle for bit_scatter32.
// out_par exists only when BIT_SCATTER_PARITY_EN is defined.
interface bit_scatter32_if;
    import bit_scatter32_pkg::*;

    logic             in_vld;
    logic             in_rdy;
    logic [IDX_W-1:0] in_idx;
    logic             in_bit;
    logic             in_last;
    logic             out_vld;
    logic             out_rdy;
    logic [SET_W-1:0] out_set;
`ifdef BIT_SCATTER_PARITY_EN
    logic             out_par;
`endif

    modport master (
        output in_vld, in_idx, in_bit, in_last, out_rdy,
`ifdef BIT_SCATTER_PARITY_EN
        input  out_par,
`endif
        input  in_rdy, out_vld, out_set
    );

    modport slave (
        input  in_vld, in_idx, in_bit, in_last, out_rdy,
`ifdef BIT_SCATTER_PARITY_EN
        output out_par,
`endif
        output in_rdy, out_vld, out_set
    );

endinterface

// File: rtl/bit_scatter32_demux.sv
// DEMUX1to32: 5-bit index to 32-bit one-hot write-enable decoder.
module bit_scatter32_demux
    import bit_scatter32_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    output logic [SET_W-1:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_idx] = 1'b1;
    end

endmodule

// File: rtl/bit_scatter32.sv
// Assembles a 32-bit set from single-bit writes and emits it as one frame.
// Optional registered even parity output enabled by BIT_SCATTER_PARITY_EN.
module bit_scatter32
    import bit_scatter32_pkg::*;
#(
    parameter logic [SET_W-1:0] FILL_VAL = 32'h0000_0000,
    parameter bit               SEQ_MODE = 1'b0
)(
    input  logic            clk,
    input  logic            rst_n,
    bit_scatter32_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SET_W-1:0] r_set;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_pos;
    logic [SET_W-1:0] w_we;
    logic [SET_W-1:0] w_set_nxt;
    logic             w_in_rdy;
    logic             w_out_vld;
    logic             w_acc;
    logic             w_rel;
    logic             w_close;

    always_comb begin
        w_pos     = SEQ_MODE ? r_cnt : bus.in_idx;
        w_acc     = bus.in_vld && w_in_rdy;
        w_rel     = w_out_vld && bus.out_rdy;
        w_close   = w_acc && (bus.in_last || (SEQ_MODE && (r_cnt == 5'd31)));
        w_set_nxt = (r_set & ~w_we) | ({SET_W{bus.in_bit}} & w_we);
    end

    bit_scatter32_demux u_demux (
        .i_idx    (w_pos),
        .o_onehot (w_we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FILL;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_close) w_state_nxt = HOLD;
            HOLD:    if (w_rel)   w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_comb begin
        w_in_rdy  = (r_state == FILL);
        w_out_vld = (r_state == HOLD);
    end

    // The set register is the output register; it only changes on accept or release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_set <= FILL_VAL;
            r_cnt <= '0;
        end else if (w_rel) begin
            r_set <= FILL_VAL;
            r_cnt <= '0;
        end else if (w_acc) begin
            r_set <= w_set_nxt;
            if (SEQ_MODE) r_cnt <= r_cnt + 5'd1;
        end
    end

`ifdef BIT_SCATTER_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_par <= ^FILL_VAL;
        else if (w_rel) r_par <= ^FILL_VAL;
        else if (w_acc) r_par <= ^w_set_nxt;
    end

    assign bus.out_par = r_par;
`endif

    assign bus.in_rdy  = w_in_rdy;
    assign bus.out_vld = w_out_vld;
    assign bus.out_set = r_set;

endmodule
